lz77_dec_ctrl: RTL and testbench
================================

Name: lz77_dec_ctrl

Overview:
- Sequencing controller for the LZ77 decoder search-buffer datapath (9-entry shift buffer, copy from position `pos` or load literal).
- Accepts (pos, len, char) codewords over a valid/ready stream and drives the datapath one character per cycle: `len` copy steps, then one literal step.
- Returns the decoded characters downstream with backpressure, and flags end-of-stream ('$') and illegal back-references.

Parameters:
- WSEARCH, 9, search buffer depth in characters; legal pos range 0..WSEARCH-1
- WCHAR, 8, character width
- END_SGN, 8'h24, end-of-stream literal ('$')
- WCNT, 16, width of emitted-character counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  codeword valid
- in_ready  out  1  codeword accepted when in_valid&in_ready
- in_pos  in  4  back-reference position
- in_len  in  3  copy length 0..7
- in_char  in  WCHAR  literal following the copy
- dp_en  out  1  datapath advance strobe (shift plus load)
- dp_lit  out  1  1: load dp_char; 0: copy srch_buf[dp_pos]
- dp_pos  out  4  copy position to datapath
- dp_char  out  WCHAR  literal to datapath
- dp_char_nxt  in  WCHAR  datapath srch_buf[0]; valid the cycle after dp_en
- out_valid  out  1  decoded character valid
- out_ready  in  1  downstream accepts
- out_char  out  WCHAR  decoded character (= dp_char_nxt)
- finish  out  1  sticky; '$' handed downstream
- err  out  1  sticky; illegal codeword seen
- char_cnt  out  WCNT  characters handed downstream, wraps at 2^WCNT

Behaviour:
- Reset (async): state=IDLE, cnt=0, fill=0, out_valid=0, finish=0, err=0, char_cnt=0, dp_en=0, held codeword cleared. Reset mid-codeword abandons it. Datapath contents are don't-care because fill=0.
- States:
  - IDLE: no codeword held.
  - RUN: codeword held, cnt = steps issued.
  - DONE: terminal until reset.
- adv = (state==RUN) & (!out_valid | out_ready). dp_en = adv.
- dp_lit = (cnt==len_q). dp_pos = pos_q. dp_char = char_q.
- On adv:
  - cnt<len_q: cnt++.
  - cnt==len_q: cnt=0.
    - If char_q==END_SGN: next state DONE.
    - Else if in_valid & in_ready: stay RUN, load new codeword.
    - Else: IDLE.
- in_ready (combinational): (state==IDLE) | (state==RUN & dp_lit & adv & char_q!=END_SGN). Zero-bubble back-to-back codewords. In DONE, in_ready=0.
- Accept checks:
  - in_pos>=WSEARCH, or (in_len!=0 & in_pos>=fill): codeword consumed, err<=1, no dp_en issued, state stays/returns IDLE.
  - in_len==0 skips the pos check (literal only, 1 step).
- fill: +1 per dp_en, saturating at WSEARCH. A copy step only reads positions previously written. Overlapping self-copy is legal because the shift occurs each step.
- Output register:
  - out_valid <= adv | (out_valid & !out_ready).
  - out_char mirrors dp_char_nxt. The datapath holds while dp_en=0, so the char is stable under stall.
  - Latency: codeword accept to first out_valid = 2 cycles. Throughput 1 char/cycle without stall.
- On out handshake: char_cnt++. If out_char==END_SGN, finish<=1.
- DONE: after the final '$' is consumed, out_valid=0 and finish=1 hold until reset.
- Simultaneous out_ready deassert and last step: adv=0, so no step or accept happens until the pending char is drained.

Decomposition:
- Package lz77_pkg: WSEARCH, WCHAR, END_SGN, state enum {IDLE, RUN, DONE}, codeword struct {pos[3:0], len[2:0], char[WCHAR-1:0]}.
- Optional sub-module lz77_out_stage: 1-entry output valid/stall register plus char_cnt. The FSM and codeword checks stay in the top.

Test Plan:
- Literal codewords (pos0,len0,'A'), (0,0,'B'), (0,0,'$'), out_ready=1 -> out chars A,B,$ on consecutive cycles. First out_valid 2 cycles after first accept. finish=1 after '$' handshake. char_cnt=3. in_ready=0 afterwards.
- After A,B,C loaded: (pos2,len3,'D') -> dp_pos=2 for 3 steps, then dp_lit. Output A,B,C,A,B,C,D, no bubble between codewords.
- Overlapping copy: after 'X', codeword (0,5,'Y') -> X then X×5 then Y. fill saturates at 9 after 9 chars.
- Illegal reference:
  - (pos4,len2,'Z') with fill=2 -> err=1, no dp_en, nothing emitted, next codeword decodes normally.
  - in_pos=9 -> err=1.
- Backpressure: out_ready held low 4 cycles mid-copy -> dp_en=0, out_char stable, no chars lost or duplicated. Sequence identical to the no-stall run.
- Async reset asserted mid-copy (cnt=2) -> outputs immediately at reset values. A new literal stream afterwards decodes correctly, and a copy with pos>=0 before any literal flags err.

Source files
------------

// File: rtl/lz77_pkg.sv
// Shared constants and types for the LZ77 decoder sequencing controller.
package lz77_pkg;

    localparam int WSEARCH = 9;
    localparam int WCHAR   = 8;
    localparam int WCNT    = 16;
    localparam int WPOS    = 4;
    localparam int WLEN    = 3;
    localparam int WFILL   = 4;

    localparam logic [WCHAR-1:0] END_SGN = 8'h24;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [WPOS-1:0]  pos;
        logic [WLEN-1:0]  len;
        logic [WCHAR-1:0] chr;
    } codeword_t;

endpackage

// File: rtl/lz77_dec_ctrl_if.sv
// Codeword input, datapath control and decoded-output stream of the LZ77 controller.
interface lz77_dec_ctrl_if;
    import lz77_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WPOS-1:0]  in_pos;
    logic [WLEN-1:0]  in_len;
    logic [WCHAR-1:0] in_char;
    logic             dp_en;
    logic             dp_lit;
    logic [WPOS-1:0]  dp_pos;
    logic [WCHAR-1:0] dp_char;
    logic [WCHAR-1:0] dp_char_nxt;
    logic             out_valid;
    logic             out_ready;
    logic [WCHAR-1:0] out_char;
    logic             finish;
    logic             err;
    logic [WCNT-1:0]  char_cnt;

    modport slave (
        input  in_valid, in_pos, in_len, in_char, dp_char_nxt, out_ready,
        output in_ready, dp_en, dp_lit, dp_pos, dp_char,
        output out_valid, out_char, finish, err, char_cnt
    );

    modport master (
        output in_valid, in_pos, in_len, in_char, dp_char_nxt, out_ready,
        input  in_ready, dp_en, dp_lit, dp_pos, dp_char,
        input  out_valid, out_char, finish, err, char_cnt
    );

endinterface

// File: rtl/lz77_out_stage.sv
// One-entry output valid/stall register with handed-off character count and sticky finish.
module lz77_out_stage
    import lz77_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             out_ready,
    input  logic [WCHAR-1:0] char_in,
    output logic             out_valid,
    output logic             finish,
    output logic [WCNT-1:0]  char_cnt
);

    logic            out_valid_q, out_valid_d;
    logic            finish_q, finish_d;
    logic [WCNT-1:0] char_cnt_q, char_cnt_d;
    logic            hs;

    // The datapath holds srch_buf[0] while no step is issued, so char_in stays valid under stall.
    always_comb begin
        hs          = out_valid_q && out_ready;
        out_valid_d = adv || (out_valid_q && !out_ready);
        finish_d    = finish_q || (hs && (char_in == END_SGN));
        char_cnt_d  = hs ? char_cnt_q + WCNT'(1) : char_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            finish_q    <= 1'b0;
            char_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            finish_q    <= finish_d;
            char_cnt_q  <= char_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign finish    = finish_q;
    assign char_cnt  = char_cnt_q;

endmodule

// File: rtl/lz77_dec_ctrl.sv
// LZ77 decoder sequencer: accepts (pos,len,char) codewords, issues len copy steps
// plus one literal step to the search-buffer datapath, and flags illegal references.
module lz77_dec_ctrl
    import lz77_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    lz77_dec_ctrl_if.slave bus
);

    state_t           state_q, state_d;
    codeword_t        cw_q, cw_d;
    logic [WLEN-1:0]  cnt_q, cnt_d;
    logic [WFILL-1:0] fill_q, fill_d, fill_eff;
    logic             err_q, err_d;

    logic             out_valid;
    logic             finish;
    logic [WCNT-1:0]  char_cnt;
    logic             adv, dp_lit, last_step, is_end, in_ready, take, bad_cw;

    always_comb begin
        dp_lit    = (cnt_q == cw_q.len);
        adv       = (state_q == RUN) && (!out_valid || bus.out_ready);
        last_step = adv && dp_lit;
        is_end    = (cw_q.chr == END_SGN);
        in_ready  = (state_q == IDLE) || (last_step && !is_end);

        // A codeword taken alongside a step may already reference the char that step writes.
        fill_eff = fill_q;
        if (adv && (fill_q != WFILL'(WSEARCH)))
            fill_eff = fill_q + WFILL'(1);

        bad_cw = (bus.in_pos >= WPOS'(WSEARCH)) ||
                 ((bus.in_len != '0) && (bus.in_pos >= fill_eff));
        take   = bus.in_valid && in_ready;

        state_d = state_q;
        cw_d    = cw_q;
        cnt_d   = cnt_q;
        fill_d  = fill_eff;
        err_d   = err_q;

        if (adv)
            cnt_d = dp_lit ? '0 : cnt_q + WLEN'(1);
        if (last_step)
            state_d = is_end ? DONE : IDLE;

        if (take) begin
            if (bad_cw) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = RUN;
                cw_d    = '{pos: bus.in_pos, len: bus.in_len, chr: bus.in_char};
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cw_q    <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
        end
    end

    lz77_out_stage u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .adv       (adv),
        .out_ready (bus.out_ready),
        .char_in   (bus.dp_char_nxt),
        .out_valid (out_valid),
        .finish    (finish),
        .char_cnt  (char_cnt)
    );

    assign bus.in_ready  = in_ready;
    assign bus.dp_en     = adv;
    assign bus.dp_lit    = dp_lit;
    assign bus.dp_pos    = cw_q.pos;
    assign bus.dp_char   = cw_q.chr;
    assign bus.out_valid = out_valid;
    assign bus.out_char  = bus.dp_char_nxt;
    assign bus.finish    = finish;
    assign bus.err       = err_q;
    assign bus.char_cnt  = char_cnt;

endmodule

// File: tb/tb_lz77_dec_ctrl.sv
// Scoreboard bench for lz77_dec_ctrl with a behavioural 9-entry search-buffer datapath.
module tb_lz77_dec_ctrl;
    import lz77_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lz77_dec_ctrl_if bus ();

    lz77_dec_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Datapath: shift in the literal or the char at dp_pos each dp_en.
    logic [7:0] sbuf [0:8];
    logic [7:0] dp_new;
    initial for (int k = 0; k < 9; k++) sbuf[k] = 8'h00;
    always @(posedge clk) begin
        if (bus.dp_en === 1'b1) begin
            if (bus.dp_lit) dp_new = bus.dp_char;
            else if (int'(bus.dp_pos) < 9) dp_new = sbuf[bus.dp_pos];
            else dp_new = 8'h00;
            for (int k = 8; k > 0; k--) sbuf[k] <= sbuf[k-1];
            sbuf[0] <= dp_new;
        end
    end
    assign bus.dp_char_nxt = sbuf[0];

    // Reference model of the decoded stream.
    logic [7:0] exp_q [$];
    logic [7:0] ref_hist [0:8];
    int ref_fill;
    int out_cnt, step_cnt, copy_cnt;

    task automatic model_push(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
        logic [7:0] ch;
        if (int'(p) >= 9 || (l != 3'd0 && int'(p) >= ref_fill)) return;
        for (int i = 0; i <= int'(l); i++) begin
            ch = (i == int'(l)) ? c : ref_hist[p];
            for (int k = 8; k > 0; k--) ref_hist[k] = ref_hist[k-1];
            ref_hist[0] = ch;
            exp_q.push_back(ch);
        end
        ref_fill = ref_fill + int'(l) + 1;
        if (ref_fill > 9) ref_fill = 9;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.dp_en === 1'b1) begin
                step_cnt++;
                if (!bus.dp_lit) copy_cnt++;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_unexpected: got %h, required no output", bus.out_char);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (bus.out_char !== e) begin
                        bad++;
                        $display("FAIL out_char #%0d: got %h, required %h", out_cnt, bus.out_char, e);
                    end
                end
                out_cnt++;
            end
        end
    end

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pos    = '0;
        bus.in_len    = '0;
        bus.in_char   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        for (int k = 0; k < 9; k++) ref_hist[k] = 8'h00;
        ref_fill = 0;
        out_cnt  = 0;
        step_cnt = 0;
        copy_cnt = 0;
        reset    = 1'b0;
    endtask

    task automatic send_cw(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
        bit ok;
        model_push(p, l, c);
        bus.in_valid = 1'b1;
        bus.in_pos   = p;
        bus.in_len   = l;
        bus.in_char  = c;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        bit ok;
        bus.in_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid && !bus.dp_en) begin ok = 1; break; end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drain_timeout: %0d chars pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        total += 6;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b, required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.finish !== 1'b0) begin bad++; $display("FAIL rst_finish: got %b, required 0", bus.finish); end
        if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b, required 0", bus.err); end
        if (bus.char_cnt !== 16'd0) begin bad++; $display("FAIL rst_char_cnt: got %0d, required 0", bus.char_cnt); end
        if (bus.dp_en !== 1'b0) begin bad++; $display("FAIL rst_dp_en: got %b, required 0", bus.dp_en); end
        do_reset();
    endtask

    task automatic test_literals();
        do_reset();
        fork
            begin
                send_cw(4'd0, 3'd0, "A");
                send_cw(4'd0, 3'd0, "B");
                send_cw(4'd0, 3'd0, "$");
                bus.in_valid = 1'b0;
            end
            begin
                int ones;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.in_valid && bus.in_ready) break;
                end
                @(negedge clk);
                total++;
                if (!(bus.dp_en === 1'b1 && bus.out_valid === 1'b0)) begin
                    bad++;
                    $display("FAIL lat_step: dp_en=%b out_valid=%b, required 1 0", bus.dp_en, bus.out_valid);
                end
                ones = 0;
                repeat (3) begin @(negedge clk); if (bus.out_valid === 1'b1) ones++; end
                total++;
                if (ones != 3) begin bad++; $display("FAIL lit_back_to_back: got %0d valid cycles, required 3", ones); end
            end
        join
        drain();
        total += 5;
        if (bus.finish !== 1'b1) begin bad++; $display("FAIL lit_finish: got %b, required 1", bus.finish); end
        if (bus.char_cnt !== 16'd3) begin bad++; $display("FAIL lit_char_cnt: got %0d, required 3", bus.char_cnt); end
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL lit_done_in_ready: got %b, required 0", bus.in_ready); end
        if (step_cnt != 3) begin bad++; $display("FAIL lit_steps: got %0d, required 3", step_cnt); end
        if (bus.err !== 1'b0) begin bad++; $display("FAIL lit_err: got %b, required 0", bus.err); end
    endtask

    task automatic test_copy();
        int ones, rises, badpos;
        do_reset();
        ones = 0; rises = 0; badpos = 0;
        fork
            begin
                send_cw(4'd0, 3'd0, "A");
                send_cw(4'd0, 3'd0, "B");
                send_cw(4'd0, 3'd0, "C");
                send_cw(4'd2, 3'd3, "D");
                bus.in_valid = 1'b0;
            end
            begin
                logic prev;
                prev = 1'b0;
                repeat (30) begin
                    @(negedge clk);
                    if (bus.out_valid && !prev) rises++;
                    if (bus.out_valid) ones++;
                    prev = bus.out_valid;
                    if (bus.dp_en && !bus.dp_lit && bus.dp_pos !== 4'd2) badpos++;
                end
            end
        join
        drain();
        total += 5;
        if (ones != 7 || rises != 1) begin bad++; $display("FAIL copy_bubble: got %0d valid in %0d bursts, required 7 in 1", ones, rises); end
        if (badpos != 0) begin bad++; $display("FAIL copy_dp_pos: got %0d wrong steps, required 0", badpos); end
        if (copy_cnt != 3) begin bad++; $display("FAIL copy_steps: got %0d, required 3", copy_cnt); end
        if (bus.char_cnt !== 16'd7) begin bad++; $display("FAIL copy_char_cnt: got %0d, required 7", bus.char_cnt); end
        if (bus.err !== 1'b0) begin bad++; $display("FAIL copy_err: got %b, required 0", bus.err); end
    endtask

    task automatic test_overlap();
        do_reset();
        send_cw(4'd0, 3'd0, "X");
        send_cw(4'd0, 3'd5, "Y");
        send_cw(4'd0, 3'd0, "P");
        send_cw(4'd0, 3'd0, "Q");
        send_cw(4'd8, 3'd2, "S");
        drain();
        total += 3;
        if (bus.err !== 1'b0) begin bad++; $display("FAIL ovl_err: got %b, required 0", bus.err); end
        if (bus.char_cnt !== 16'd12) begin bad++; $display("FAIL ovl_char_cnt: got %0d, required 12", bus.char_cnt); end
        if (copy_cnt != 7) begin bad++; $display("FAIL ovl_copies: got %0d, required 7", copy_cnt); end
    endtask

    task automatic test_illegal();
        do_reset();
        send_cw(4'd0, 3'd0, "A");
        send_cw(4'd0, 3'd0, "B");
        send_cw(4'd4, 3'd2, "Z");
        send_cw(4'd1, 3'd1, "E");
        drain();
        total += 3;
        if (bus.err !== 1'b1) begin bad++; $display("FAIL ill_fill_err: got %b, required 1", bus.err); end
        if (step_cnt != 4) begin bad++; $display("FAIL ill_steps: got %0d, required 4", step_cnt); end
        if (bus.char_cnt !== 16'd4) begin bad++; $display("FAIL ill_char_cnt: got %0d, required 4", bus.char_cnt); end

        do_reset();
        send_cw(4'd9, 3'd0, "F");
        drain();
        total += 2;
        if (bus.err !== 1'b1) begin bad++; $display("FAIL ill_pos9_err: got %b, required 1", bus.err); end
        if (step_cnt != 0) begin bad++; $display("FAIL ill_pos9_steps: got %0d, required 0", step_cnt); end

        do_reset();
        for (int i = 0; i < 7; i++) send_cw(4'd0, 3'd0, 8'h61 + 8'(i));
        send_cw(4'd8, 3'd0, "h");
        total++;
        if (bus.err !== 1'b0) begin bad++; $display("FAIL ill_len0_skip: got err %b, required 0", bus.err); end
        send_cw(4'd8, 3'd1, "i");
        drain();
        total += 2;
        if (bus.err !== 1'b1) begin bad++; $display("FAIL ill_fill8_err: got %b, required 1", bus.err); end
        if (bus.char_cnt !== 16'd8) begin bad++; $display("FAIL ill_fill8_cnt: got %0d, required 8", bus.char_cnt); end
    endtask

    task automatic test_backpressure();
        int stall_bad;
        do_reset();
        stall_bad = 0;
        fork
            begin
                send_cw(4'd0, 3'd0, "A");
                send_cw(4'd0, 3'd0, "B");
                send_cw(4'd0, 3'd0, "C");
                send_cw(4'd2, 3'd3, "D");
                bus.in_valid = 1'b0;
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    #1;
                    if (out_cnt >= 4) begin seen = 1; break; end
                end
                total++;
                if (!seen) begin bad++; $display("FAIL bp_wait: got %0d chars, required 4", out_cnt); end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (bus.dp_en !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_char !== "B") stall_bad++;
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        total += 3;
        if (stall_bad != 0) begin bad++; $display("FAIL bp_stall: got %0d bad stall cycles, required 0", stall_bad); end
        if (bus.char_cnt !== 16'd7) begin bad++; $display("FAIL bp_char_cnt: got %0d, required 7", bus.char_cnt); end
        if (step_cnt != 7) begin bad++; $display("FAIL bp_steps: got %0d, required 7", step_cnt); end
    endtask

    task automatic test_async_reset();
        bit seen;
        do_reset();
        send_cw(4'd0, 3'd0, "A");
        send_cw(4'd0, 3'd0, "B");
        send_cw(4'd0, 3'd0, "C");
        send_cw(4'd2, 3'd5, "D");
        bus.in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (copy_cnt >= 2) begin seen = 1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL ar_wait: got %0d copies, required 2", copy_cnt); end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total += 5;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ar_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.dp_en !== 1'b0) begin bad++; $display("FAIL ar_dp_en: got %b, required 0", bus.dp_en); end
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ar_in_ready: got %b, required 1", bus.in_ready); end
        if (bus.char_cnt !== 16'd0) begin bad++; $display("FAIL ar_char_cnt: got %0d, required 0", bus.char_cnt); end
        if (bus.finish !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL ar_flags: got finish=%b err=%b, required 0 0", bus.finish, bus.err); end
        do_reset();
        send_cw(4'd0, 3'd1, "M");
        send_cw(4'd0, 3'd0, "K");
        send_cw(4'd0, 3'd0, "L");
        drain();
        total += 2;
        if (bus.err !== 1'b1) begin bad++; $display("FAIL ar_copy_err: got %b, required 1", bus.err); end
        if (bus.char_cnt !== 16'd2) begin bad++; $display("FAIL ar_char_cnt_after: got %0d, required 2", bus.char_cnt); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pos    = '0;
        bus.in_len    = '0;
        bus.in_char   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_literals();
        test_copy();
        test_overlap();
        test_illegal();
        test_backpressure();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
